fp_sum_sq_32_16_16: RTL and testbench

//   Multi-cycle fixed-point sum-of-squares stage: out = a*a + b*b, Q(INT).(FRAC), unsigned, saturating.

---
 rtl/fp_sum_sq_32_16_16.sv | 119 +++++++++++
 tb/tb_fp_sum_sq_32_16_16.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_sum_sq_32_16_16.sv
// Fixed-point sum of squares: out = sat(|a|^2 + |b|^2 >> FRAC_WIDTH).
// Squares are formed with a radix-2 shift-add multiplier, one partial
// product per cycle, sharing a single accumulator for both operands.
module fp_sum_sq_32_16_16 #(
  parameter int WIDTH      = 32,
  parameter int INT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int AW = 2 * WIDTH + 1;   // room for the carry of sq_a + sq_b

  typedef enum logic [1:0] {IDLE, SQ_A, SQ_B, FIN} state_t;

  state_t              state_reg, state_next;
  logic [CW-1:0]       cnt_reg;
  logic [2*WIDTH-1:0]  mcand_reg;      // multiplicand, shifted left each cycle
  logic [WIDTH-1:0]    mplier_reg;     // multiplier, shifted right each cycle
  logic [WIDTH-1:0]    mag_b_reg;      // |b| parked until SQ_B starts
  logic [AW-1:0]       acc_reg;

  logic [WIDTH-1:0]    mag_a, mag_b;
  logic [AW-1:0]       pp, acc_next;
  logic                last;
  logic [WIDTH-1:0]    sat_out;
  logic                sat_ovf;

  // Unary minus on WIDTH bits maps the most negative value onto 2^(WIDTH-1),
  // which is exactly its magnitude when read as unsigned.
  assign mag_a = a[WIDTH-1] ? -a : a;
  assign mag_b = b[WIDTH-1] ? -b : b;

  assign last     = (cnt_reg == CW'(WIDTH - 1));
  assign pp       = mplier_reg[0] ? {1'b0, mcand_reg} : '0;
  assign acc_next = acc_reg + pp;

  // Anything at or above bit WIDTH after dropping the fraction saturates.
  assign sat_ovf = |acc_next[AW-1:WIDTH+FRAC_WIDTH];
  assign sat_out = sat_ovf ? {WIDTH{1'b1}} : acc_next[WIDTH+FRAC_WIDTH-1:FRAC_WIDTH];

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state and handshake/done decode.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SQ_A;
      end
      SQ_A: if (last) state_next = SQ_B;
      SQ_B: if (last) state_next = FIN;
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Shift-add datapath; the result is registered on the final SQ_B edge so
  // out/overflow are already valid during the FIN (done) cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      mag_b_reg  <= '0;
      acc_reg    <= '0;
      out        <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            mcand_reg  <= {{WIDTH{1'b0}}, mag_a};
            mplier_reg <= mag_a;
            mag_b_reg  <= mag_b;
            acc_reg    <= '0;
            cnt_reg    <= '0;
          end
        end
        SQ_A, SQ_B: begin
          acc_reg <= acc_next;
          cnt_reg <= last ? '0 : cnt_reg + CW'(1);
          if (last && state_reg == SQ_A) begin
            mcand_reg  <= {{WIDTH{1'b0}}, mag_b_reg};
            mplier_reg <= mag_b_reg;
          end else begin
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
          end
          if (last && state_reg == SQ_B) begin
            out      <= sat_out;
            overflow <= sat_ovf;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_sum_sq_32_16_16.sv
// Bench for fp_sum_sq_32_16_16: directed corner cases, back-to-back
// operation, mid-operation reset and random pairs against a 64-bit model.
module tb_fp_sum_sq_32_16_16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] out;
  logic        overflow;
  logic        done;

  int checks = 0;
  int errors = 0;
  logic prev_done = 1'b0;

  fp_sum_sq_32_16_16 dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out(out), .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: exact squares in 64-bit arithmetic, drop fraction, saturate.
  function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    logic [64:0] s;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    s  = {1'b0, 64'(sx * sx)} + {1'b0, 64'(sy * sy)};
    s  = s >> 16;
    if (s > 65'h0_0000_0000_FFFF_FFFF) return {1'b1, 32'hFFFF_FFFF};
    return {1'b0, s[31:0]};
  endfunction

  // done must never be high on two consecutive cycles.
  always @(negedge clk) begin
    if (done) check("done_width", {63'd0, prev_done}, 64'd0);
    prev_done <= done;
  end

  // Called just after the accepting edge; waits for done and checks it.
  task automatic wait_result(input string tag, input logic [31:0] e_out, input logic e_ovf);
    logic [31:0] prev_out;
    int n;
    prev_out = out;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) check({tag, "_held"}, {32'd0, out}, {32'd0, prev_out});
    end while (!done && n < 200);
    check({tag, "_latency"}, 64'(n), 64'd65);
    check({tag, "_out"}, {32'd0, out}, {32'd0, e_out});
    check({tag, "_ovf"}, {63'd0, overflow}, {63'd0, e_ovf});
    $display("pair %s out=%h ovf=%0d cycles=%0d", tag, out, overflow, n);
    @(negedge clk);
    check({tag, "_ready"}, {63'd0, in_ready}, 64'd1);
  endtask

  task automatic run_pair(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                          input logic [31:0] e_out, input logic e_ovf);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, {63'd0, in_ready}, 64'd1);
    a = xa;
    b = xb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    wait_result(tag, e_out, e_ovf);
  endtask

  initial begin
    logic [32:0] m;
    logic [31:0] ra, rb;
    int lowc, got;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out", {32'd0, out}, 64'd0);
    check("rst_ovf", {63'd0, overflow}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_ready", {63'd0, in_ready}, 64'd1);
    reset_n = 1'b1;

    // Directed cases
    run_pair("3_4",     32'h0003_0000, 32'h0004_0000, 32'h0019_0000, 1'b0);
    run_pair("m15_0",   32'hFFFE_8000, 32'h0000_0000, 32'h0002_4000, 1'b0);
    run_pair("0_m15",   32'h0000_0000, 32'hFFFE_8000, 32'h0002_4000, 1'b0);
    run_pair("lsb",     32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b0);
    run_pair("x100",    32'h0000_0100, 32'h0000_0100, 32'h0000_0002, 1'b0);
    run_pair("181",     32'h00B5_0000, 32'h00B5_0000, 32'hFFF2_0000, 1'b0);
    run_pair("182",     32'h00B6_0000, 32'h00B6_0000, 32'hFFFF_FFFF, 1'b1);
    run_pair("minneg",  32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1);
    run_pair("minneg2", 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);

    // Back-to-back with in_valid held high and a/b changing while busy
    @(negedge clk);
    a = 32'hFFFD_0000;          // -3.0
    b = 32'h0004_0000;          //  4.0
    in_valid = 1'b1;
    @(posedge clk);
    lowc = 0;
    got  = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (done) begin
        got++;
        check("b2b_first_out", {32'd0, out}, 64'h0000_0000_0019_0000);
        a = 32'h0001_0000;      // 1.0
        b = 32'hFFFE_0000;      // -2.0
      end else if (got == 0) begin
        a = $urandom;
        b = $urandom;
      end
      if (in_ready) break;
      lowc++;
    end
    check("b2b_busy", 64'(lowc), 64'd65);
    check("b2b_dones", 64'(got), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    wait_result("b2b_second", 32'h0005_0000, 1'b0);

    // Reset in the middle of SQ_A
    @(negedge clk);
    a = 32'h0002_0000;
    b = 32'h0001_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_out", {32'd0, out}, 64'd0);
    check("abort_ovf", {63'd0, overflow}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_ready", {63'd0, in_ready}, 64'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    got = 0;
    repeat (80) begin
      @(negedge clk);
      if (done) got++;
    end
    check("abort_no_done", 64'(got), 64'd0);
    run_pair("after_rst", 32'h0003_0000, 32'h0004_0000, 32'h0019_0000, 1'b0);

    // Random pairs with a bias toward values near the saturation boundary
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: begin ra = $urandom; rb = $urandom; end
        1: begin
          ra = $urandom; ra = {{8{ra[23]}}, ra[23:0]};
          rb = $urandom; rb = {{8{rb[23]}}, rb[23:0]};
        end
        2: begin
          ra = $urandom_range(0, 32'h00B6_0000);
          rb = $urandom_range(0, 32'h00B6_0000);
          if ($urandom_range(0, 1) == 1) ra = -ra;
          if ($urandom_range(0, 1) == 1) rb = -rb;
        end
        default: begin
          ra = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
          rb = $urandom_range(0, 32'h0000_FFFF);
        end
      endcase
      m = model(ra, rb);
      run_pair($sformatf("rnd%0d", i), ra, rb, m[31:0], m[32]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
